// File: rtl/ssd_scan_decoder.sv
// rtl/ssd_scan_decoder.sv - seven-segment scan bus reader, recovers per-digit hex frames
//
// Samples an active-low multiplexed segment/anode bus, accepts a digit once its
// pattern has been stable for STABLE_CYCLES samples, and publishes a full frame
// once every digit position has been captured.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   seg_n        segment bus, active-low, [7]=dp, [6:0]=g..a
//   an_n         digit enables, active-low, bit i selects digit i
//   value        recovered nibbles, digit i at [4i+3:4i]
//   dp, blank    per-digit decimal point lit / digit dark
//   frame_valid  one-cycle pulse when value/dp/blank/frame_err update
//   frame_err    published frame contained an invalid pattern or an enable collision
//   stale        no frame published for TIMEOUT cycles
module ssd_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     an_n,
  output logic [4*NUM_DIGITS-1:0]   value,
  output logic [NUM_DIGITS-1:0]     dp,
  output logic [NUM_DIGITS-1:0]     blank,
  output logic                      frame_valid,
  output logic                      frame_err,
  output logic                      stale
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

  // returns {valid, blank, nibble}
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 6'b10_0000;
      7'h79: decode = 6'b10_0001;
      7'h24: decode = 6'b10_0010;
      7'h30: decode = 6'b10_0011;
      7'h19: decode = 6'b10_0100;
      7'h12: decode = 6'b10_0101;
      7'h02: decode = 6'b10_0110;
      7'h78: decode = 6'b10_0111;
      7'h00: decode = 6'b10_1000;
      7'h10: decode = 6'b10_1001;
      7'h08: decode = 6'b10_1010;
      7'h03: decode = 6'b10_1011;
      7'h46: decode = 6'b10_1100;
      7'h21: decode = 6'b10_1101;
      7'h06: decode = 6'b10_1110;
      7'h0E: decode = 6'b10_1111;
      7'h7F: decode = 6'b11_0000;
      default: decode = 6'b00_0000;
    endcase
  endfunction

  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   an_q;
  // The input registers reset to zero, which reads as "all digits selected";
  // in_valid keeps that reset artefact from being seen as a collision.
  logic                    in_valid;
  state_t                  state, state_d;
  logic [IW-1:0]           cur_idx, cur_idx_d;
  logic [7:0]              cur_seg, cur_seg_d;
  logic [CW-1:0]           count, count_d;
  logic [4*NUM_DIGITS-1:0] slot_val;
  logic [NUM_DIGITS-1:0]   slot_dp, slot_blank, seen;
  logic                    err_flag;
  logic [TW-1:0]           stale_cnt;

  logic [NUM_DIGITS-1:0]   sel;
  logic                    single, coll, same, capture, coll_err, start, publish;
  logic [IW-1:0]           idx;
  logic [5:0]              dec;

  assign sel     = in_valid ? ~an_q : '0;
  assign single  = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  assign coll    = (sel != '0) && !single;
  assign same    = (idx == cur_idx) && (seg_q == cur_seg);
  assign dec     = decode(seg_q[6:0]);
  assign publish = &seen;
  assign stale   = (stale_cnt == TMAX);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) idx = IW'(i);
    end
  end

  always_comb begin
    state_d   = state;
    cur_idx_d = cur_idx;
    cur_seg_d = cur_seg;
    count_d   = count;
    capture   = 1'b0;
    coll_err  = 1'b0;
    start     = 1'b0;
    case (state)
      TRACK: begin
        if (single && same) begin
          count_d = count + 1'b1;
          if (count_d == CMAX) begin
            capture = 1'b1;
            state_d = DONE;
          end
        end else begin
          start = 1'b1;
        end
      end
      DONE:    start = !(single && same);
      default: start = 1'b1;
    endcase
    // Anything that breaks the current track is treated exactly like IDLE.
    if (start) begin
      if (single) begin
        cur_idx_d = idx;
        cur_seg_d = seg_q;
        count_d   = CW'(1);
        if (CMAX == CW'(1)) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          state_d = TRACK;
        end
      end else begin
        state_d  = IDLE;
        count_d  = '0;
        coll_err = coll;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= '0;
      an_q        <= '0;
      in_valid    <= 1'b0;
      state       <= IDLE;
      cur_idx     <= '0;
      cur_seg     <= '0;
      count       <= '0;
      slot_val    <= '0;
      slot_dp     <= '0;
      slot_blank  <= '0;
      seen        <= '0;
      err_flag    <= 1'b0;
      value       <= '0;
      dp          <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      stale_cnt   <= '0;
    end else begin
      seg_q    <= seg_n;
      an_q     <= an_n;
      in_valid <= 1'b1;
      state    <= state_d;
      cur_idx  <= cur_idx_d;
      cur_seg  <= cur_seg_d;
      count    <= count_d;
      if (capture) begin
        slot_val[4*idx +: 4] <= dec[3:0];
        slot_dp[idx]         <= ~seg_q[7];
        slot_blank[idx]      <= dec[4];
      end
      // Clear on publish, but a capture on the same edge belongs to the new frame.
      seen     <= (publish ? '0 : seen) | (capture ? (NUM_DIGITS'(1) << idx) : '0);
      err_flag <= (publish ? 1'b0 : err_flag) | coll_err | (capture && !dec[5]);
      frame_valid <= publish;
      if (publish) begin
        value     <= slot_val;
        dp        <= slot_dp;
        blank     <= slot_blank;
        frame_err <= err_flag;
        stale_cnt <= '0;
      end else if (stale_cnt != TMAX) begin
        stale_cnt <= stale_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb/tb_ssd_scan_decoder.sv - directed self-checking bench for ssd_scan_decoder
module tb_ssd_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  dp, blank;
  logic        frame_valid, frame_err, stale;

  int n_cmp = 0;
  int n_err = 0;
  int fv_cnt = 0;
  int fv_base;

  ssd_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
    .value(value), .dp(dp), .blank(blank),
    .frame_valid(frame_valid), .frame_err(frame_err), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_valid === 1'b1) fv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int d, input logic [7:0] s, input int n);
    an_n  = ~(4'b0001 << d);
    seg_n = s;
    tick(n);
  endtask

  task automatic idle(input int n);
    an_n  = 4'hF;
    seg_n = 8'hFF;
    tick(n);
  endtask

  task automatic frame(input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3);
    fv_base = fv_cnt;
    show(0, s0, 6);
    show(1, s1, 6);
    show(2, s2, 6);
    show(3, s3, 6);
    idle(3);
  endtask

  initial begin
    rst_n = 1'b0;
    an_n  = 4'hF;
    seg_n = 8'hFF;
    tick(3);
    check("reset_value", value, 0);
    check("reset_dp", dp, 0);
    check("reset_blank", blank, 0);
    check("reset_fv", frame_valid, 0);
    check("reset_err", frame_err, 0);
    check("reset_stale", stale, 0);
    rst_n = 1'b1;

    tick(15);
    check("stale_before", stale, 0);
    tick(1);
    check("stale_at_timeout", stale, 1);
    check("idle_no_frame", fv_cnt, 0);

    frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
    check("scan_frames", fv_cnt - fv_base, 1);
    check("scan_value", value, 16'h12AF);
    check("scan_err", frame_err, 0);
    check("scan_dp", dp, 0);
    check("scan_blank", blank, 0);
    check("stale_cleared", stale, 0);
    frame(8'h8E, 8'h88, 8'hA4, 8'hF9);
    check("rescan_frames", fv_cnt - fv_base, 1);

    fv_base = fv_cnt;
    show(0, 8'hC0, 6);
    show(1, 8'hF9, 6);
    show(2, 8'hA4, 2);
    show(2, 8'h88, 6);
    show(3, 8'hB0, 6);
    idle(3);
    check("glitch_frames", fv_cnt - fv_base, 1);
    check("glitch_value", value, 16'h3A10);

    frame(8'h40, 8'hFF, 8'hB0, 8'h99);
    check("dpb_value", value, 16'h4300);
    check("dpb_dp", dp, 4'b0001);
    check("dpb_blank", blank, 4'b0010);
    check("dpb_err", frame_err, 0);

    frame(8'hF9, 8'hF9, 8'hF9, 8'h55);
    check("inval_value", value, 16'h0111);
    check("inval_err", frame_err, 1);
    frame(8'hF9, 8'hF9, 8'hF9, 8'h99);
    check("clean_value", value, 16'h4111);
    check("clean_err", frame_err, 0);

    fv_base = fv_cnt;
    show(0, 8'hF9, 6);
    show(1, 8'hA4, 6);
    an_n  = 4'b0011;
    seg_n = 8'h80;
    tick(8);
    show(2, 8'hB0, 6);
    show(3, 8'h99, 6);
    idle(3);
    check("coll_frames", fv_cnt - fv_base, 1);
    check("coll_value", value, 16'h4321);
    check("coll_err", frame_err, 1);

    show(0, 8'hC0, 6);
    show(1, 8'hC0, 6);
    idle(1);
    rst_n = 1'b0;
    tick(2);
    check("mid_reset_value", value, 0);
    check("mid_reset_err", frame_err, 0);
    check("mid_reset_fv", frame_valid, 0);
    rst_n = 1'b1;
    fv_base = fv_cnt;
    show(2, 8'hB0, 6);
    show(3, 8'h99, 6);
    idle(3);
    check("post_reset_partial", fv_cnt - fv_base, 0);
    show(0, 8'h8E, 6);
    show(1, 8'h88, 6);
    idle(3);
    check("post_reset_frames", fv_cnt - fv_base, 1);
    check("post_reset_value", value, 16'h43AF);
    check("post_reset_err", frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "bench timeout");
  end

endmodule
